// File: rtl/ray_unit_multislot_pkg.sv
// Shared types and saturating Q16.16 fixed-point helpers for the multi-slot ray marcher.
// Scene: a single axis-aligned cube of half-size 1 centred at the origin.
package ray_unit_multislot_pkg;

    localparam int unsigned FP_FRAC = 16;

    typedef logic signed [31:0] fp_t;

    typedef struct packed {
        fp_t x;
        fp_t y;
        fp_t z;
    } vec3_t;

    localparam fp_t FP_MAX       = 32'sh7FFF_FFFF;
    localparam fp_t FP_MIN       = 32'sh8000_0000;
    localparam fp_t FP_ONE       = 32'sh0001_0000;
    localparam fp_t FP_FIVE      = 32'sh0005_0000;
    localparam fp_t FP_HUNDREDTH = 32'sh0000_028F;

    localparam fp_t DEFAULT_EPS      = FP_HUNDREDTH >>> 1;
    localparam fp_t DEFAULT_MAX_DIST = FP_FIVE;

    // Slot fields are sized for the widest supported configuration.
    localparam int unsigned TAG_W   = 16;
    localparam int unsigned DEPTH_W = 16;
    localparam int unsigned COLOR_W = 16;

    typedef enum logic [1:0] {
        RS_Free,
        RS_March,
        RS_Done
    } RaySlotState;

    typedef struct packed {
        vec3_t              origin;
        vec3_t              direction;
        logic [TAG_W-1:0]   hcount;
        logic [TAG_W-1:0]   vcount;
        fp_t                eps;
        fp_t                max_dist;
        logic [DEPTH_W-1:0] depth;
        logic [COLOR_W-1:0] color;
        logic               hit;
    } ray_slot_t;

    function automatic fp_t fp_add(fp_t a, fp_t b);
        logic signed [32:0] s;
        s = 33'(a) + 33'(b);
        if (s[32] != s[31]) return s[32] ? FP_MIN : FP_MAX;
        return s[31:0];
    endfunction

    function automatic fp_t fp_neg(fp_t a);
        return (a == FP_MIN) ? FP_MAX : -a;
    endfunction

    function automatic fp_t fp_sub(fp_t a, fp_t b);
        return fp_add(a, fp_neg(b));
    endfunction

    function automatic fp_t fp_mul(fp_t a, fp_t b);
        logic signed [63:0] p;
        p = (64'(a) * 64'(b)) >>> FP_FRAC;
        if (p > 64'(FP_MAX)) return FP_MAX;
        if (p < 64'(FP_MIN)) return FP_MIN;
        return p[31:0];
    endfunction

    function automatic fp_t fp_abs(fp_t a);
        return (a < 0) ? fp_neg(a) : a;
    endfunction

    function automatic fp_t fp_max(fp_t a, fp_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic vec3_t vec3_add(vec3_t a, vec3_t b);
        vec3_t r;
        r.x = fp_add(a.x, b.x);
        r.y = fp_add(a.y, b.y);
        r.z = fp_add(a.z, b.z);
        return r;
    endfunction

    function automatic vec3_t vec3_scale(vec3_t v, fp_t s);
        vec3_t r;
        r.x = fp_mul(v.x, s);
        r.y = fp_mul(v.y, s);
        r.z = fp_mul(v.z, s);
        return r;
    endfunction

    // Chebyshev distance to the unit cube; never overestimates the true distance.
    function automatic fp_t sdf_cube(vec3_t p);
        return fp_sub(fp_max(fp_abs(p.x), fp_max(fp_abs(p.y), fp_abs(p.z))), FP_ONE);
    endfunction

endpackage

// File: rtl/ray_unit_multislot_if.sv
// Ray input and result output bundle of the multi-slot ray marcher.
interface ray_unit_multislot_if #(
    parameter int unsigned H_BITS     = 10,
    parameter int unsigned V_BITS     = 10,
    parameter int unsigned DEPTH_BITS = 5,
    parameter int unsigned COLOR_BITS = 4
) ();
    import ray_unit_multislot_pkg::*;

    vec3_t                 ray_origin_in;
    vec3_t                 ray_direction_in;
    logic [H_BITS-1:0]     hcount_in;
    logic [V_BITS-1:0]     vcount_in;
    fp_t                   hit_eps_in;
    fp_t                   max_dist_in;
    logic                  valid_in;
    logic                  ready_out;
    logic [H_BITS-1:0]     hcount_out;
    logic [V_BITS-1:0]     vcount_out;
    logic [COLOR_BITS-1:0] color_out;
    logic                  hit_out;
    logic [DEPTH_BITS-1:0] depth_out;
    logic                  valid_out;
    logic                  ready_in;

    modport slave (
        input  ray_origin_in, ray_direction_in, hcount_in, vcount_in, hit_eps_in, max_dist_in,
        input  valid_in, ready_in,
        output ready_out, hcount_out, vcount_out, color_out, hit_out, depth_out, valid_out
    );

    modport master (
        output ray_origin_in, ray_direction_in, hcount_in, vcount_in, hit_eps_in, max_dist_in,
        output valid_in, ready_in,
        input  ready_out, hcount_out, vcount_out, color_out, hit_out, depth_out, valid_out
    );

endinterface

// File: rtl/ray_slot_prio_enc.sv
// Lowest-index-set encoder with a found flag.
module ray_slot_prio_enc #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned IDX_BITS = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  i_req,
    output logic [IDX_BITS-1:0] o_idx,
    output logic                o_found
);

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_req[i] && !o_found) begin
                o_idx   = IDX_BITS'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ray_unit_multislot.sv
// NUM_SLOTS rays in flight sharing one round-robin SDF/march datapath, with a
// valid/ready result port. Define RAY_UNIT_PERF_EN to add handshake/step counters.
module ray_unit_multislot
    import ray_unit_multislot_pkg::*;
#(
    parameter int unsigned H_BITS        = 10,
    parameter int unsigned V_BITS        = 10,
    parameter int unsigned MAX_RAY_DEPTH = 16,
    parameter int unsigned NUM_SLOTS     = 4,
    parameter int unsigned COLOR_BITS    = 4
) (
    input logic                 clk_in,
    input logic                 rst_n_in,
    ray_unit_multislot_if.slave bus
`ifdef RAY_UNIT_PERF_EN
    ,
    output logic [31:0]         perf_rays_out,
    output logic [31:0]         perf_steps_out
`endif
);

    localparam int unsigned SLOT_BITS  = $clog2(NUM_SLOTS);
    localparam int unsigned DEPTH_BITS = $clog2(MAX_RAY_DEPTH + 1);
    localparam logic [DEPTH_W-1:0] DepthLimit = DEPTH_W'(MAX_RAY_DEPTH);
    localparam logic [DEPTH_W-1:0] ShadeMax   = DEPTH_W'((1 << COLOR_BITS) - 1);

    RaySlotState           r_state [NUM_SLOTS];
    ray_slot_t             r_slot  [NUM_SLOTS];
    logic [SLOT_BITS-1:0]  r_ptr;
    logic                  r_valid;
    logic [SLOT_BITS-1:0]  r_sel;
    logic [H_BITS-1:0]     r_hcount;
    logic [V_BITS-1:0]     r_vcount;
    logic [COLOR_BITS-1:0] r_color;
    logic                  r_hit;
    logic [DEPTH_BITS-1:0] r_depth;

    logic [NUM_SLOTS-1:0]  w_free_mask;
    logic [NUM_SLOTS-1:0]  w_done_mask;
    logic [SLOT_BITS-1:0]  w_free_idx;
    logic [SLOT_BITS-1:0]  w_done_idx;
    logic                  w_free_found;
    logic                  w_done_found;
    logic                  w_accept;
    logic                  w_step;
    logic                  w_hit;
    logic                  w_miss;
    logic                  w_out_fire;
    logic                  w_load;
    fp_t                   w_dist;
    vec3_t                 w_next_origin;
    logic [DEPTH_W-1:0]    w_half_depth;
    logic [DEPTH_W-1:0]    w_shade;
    ray_slot_t             w_new_slot;

    // The slot currently on the output port is excluded so a new one can load on handshake.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_free_mask[i] = (r_state[i] == RS_Free);
            w_done_mask[i] = (r_state[i] == RS_Done) && !(r_valid && (r_sel == SLOT_BITS'(i)));
        end
    end

    ray_slot_prio_enc #(
        .NUM_REQ (NUM_SLOTS)
    ) u_free_enc (
        .i_req   (w_free_mask),
        .o_idx   (w_free_idx),
        .o_found (w_free_found)
    );

    ray_slot_prio_enc #(
        .NUM_REQ (NUM_SLOTS)
    ) u_done_enc (
        .i_req   (w_done_mask),
        .o_idx   (w_done_idx),
        .o_found (w_done_found)
    );

    always_comb begin
        w_new_slot           = '0;
        w_new_slot.origin    = bus.ray_origin_in;
        w_new_slot.direction = bus.ray_direction_in;
        w_new_slot.hcount    = TAG_W'(bus.hcount_in);
        w_new_slot.vcount    = TAG_W'(bus.vcount_in);
        w_new_slot.eps       = bus.hit_eps_in;
        w_new_slot.max_dist  = bus.max_dist_in;
    end

    assign w_accept      = bus.valid_in && w_free_found;
    assign w_step        = (r_state[r_ptr] == RS_March);
    assign w_dist        = sdf_cube(r_slot[r_ptr].origin);
    assign w_hit         = $signed(w_dist) < $signed(r_slot[r_ptr].eps);
    assign w_miss        = ($signed(w_dist) > $signed(r_slot[r_ptr].max_dist))
                           || (r_slot[r_ptr].depth == DepthLimit);
    assign w_next_origin = vec3_add(r_slot[r_ptr].origin,
                                    vec3_scale(r_slot[r_ptr].direction, w_dist));
    assign w_half_depth  = r_slot[r_ptr].depth >> 1;
    assign w_shade       = (w_half_depth >= ShadeMax) ? '0 : ShadeMax - w_half_depth;
    assign w_out_fire    = r_valid && bus.ready_in;
    assign w_load        = w_done_found && (!r_valid || bus.ready_in);

    // Accept, step and free always address different slots, so their writes never collide.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_ptr <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= RS_Free;
                r_slot[i]  <= '0;
            end
        end else begin
            r_ptr <= r_ptr + SLOT_BITS'(1);
            if (w_accept) begin
                r_state[w_free_idx] <= RS_March;
                r_slot[w_free_idx]  <= w_new_slot;
            end
            if (w_step) begin
                if (w_hit) begin
                    r_state[r_ptr]       <= RS_Done;
                    r_slot[r_ptr].color  <= w_shade;
                    r_slot[r_ptr].hit    <= 1'b1;
                end else if (w_miss) begin
                    r_state[r_ptr]       <= RS_Done;
                    r_slot[r_ptr].color  <= '0;
                    r_slot[r_ptr].hit    <= 1'b0;
                end else begin
                    r_slot[r_ptr].origin <= w_next_origin;
                    r_slot[r_ptr].depth  <= r_slot[r_ptr].depth + DEPTH_W'(1);
                end
            end
            if (w_out_fire) begin
                r_state[r_sel] <= RS_Free;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_valid  <= 1'b0;
            r_sel    <= '0;
            r_hcount <= '0;
            r_vcount <= '0;
            r_color  <= '0;
            r_hit    <= 1'b0;
            r_depth  <= '0;
        end else if (w_load) begin
            r_valid  <= 1'b1;
            r_sel    <= w_done_idx;
            r_hcount <= r_slot[w_done_idx].hcount[H_BITS-1:0];
            r_vcount <= r_slot[w_done_idx].vcount[V_BITS-1:0];
            r_color  <= r_slot[w_done_idx].color[COLOR_BITS-1:0];
            r_hit    <= r_slot[w_done_idx].hit;
            r_depth  <= r_slot[w_done_idx].depth[DEPTH_BITS-1:0];
        end else if (w_out_fire) begin
            r_valid  <= 1'b0;
        end
    end

    assign bus.ready_out  = w_free_found;
    assign bus.valid_out  = r_valid;
    assign bus.hcount_out = r_hcount;
    assign bus.vcount_out = r_vcount;
    assign bus.color_out  = r_color;
    assign bus.hit_out    = r_hit;
    assign bus.depth_out  = r_depth;

`ifdef RAY_UNIT_PERF_EN
    logic [31:0] r_perf_rays;
    logic [31:0] r_perf_steps;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_perf_rays  <= '0;
            r_perf_steps <= '0;
        end else begin
            if (w_out_fire) r_perf_rays  <= r_perf_rays + 32'd1;
            if (w_step)     r_perf_steps <= r_perf_steps + 32'd1;
        end
    end

    assign perf_rays_out  = r_perf_rays;
    assign perf_steps_out = r_perf_steps;
`endif

endmodule
